// File: rtl/cout_nibble_tx.sv
// ---------------------------------------------------------------------------
// cout_nibble_tx
//
// Purpose:
//   Transmit end of the 4-bit nibble interface for the SHA-256 digest. On a
//   load pulse while idle, the 256-bit final hash {H0..H7} is captured into a
//   shift register. It is then streamed out MSB-first, one nibble per
//   valid/ready handshake. One cycle after the final nibble is accepted, a
//   single-cycle done pulse is raised.
//
// Ports:
//   clk         in   1      system clock, rising edge
//   rst         in   1      asynchronous reset, active-low
//   load        in   1      capture digest and start streaming (IDLE only)
//   digest      in   DIG_W  {H0,...,H7}, H0 in the top 32 bits
//   dout        out  NIB_W  current nibble
//   dout_valid  out  1      dout holds a valid nibble
//   dout_ready  in   1      sink accepts dout this cycle
//   word_idx    out  3      which Hx word the current nibble belongs to
//   last        out  1      current nibble is the final one
//   busy        out  1      transmission in progress (load ignored)
//   done        out  1      one-cycle pulse after the last nibble is accepted
//
// Every output is decoded from registered state only, so there is no
// combinational path from any input to any output.
// ---------------------------------------------------------------------------
module cout_nibble_tx #(
  parameter int NIB_W = 4,
  parameter int DIG_W = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIG_W-1:0] digest,
  output logic [NIB_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [2:0]       word_idx,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam int NUM_NIB      = DIG_W / NIB_W;
  localparam int CNT_W        = $clog2(NUM_NIB);
  localparam int WORD_W       = DIG_W / 8;
  localparam int NIB_PER_WORD = WORD_W / NIB_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DIG_W-1:0]   sreg_q,  sreg_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          sreg_d  = digest;
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        // dout_valid is constantly 1 in SEND, so ready alone completes a handshake
        if (dout_ready) begin
          sreg_d = {sreg_q[DIG_W-NIB_W-1:0], {NIB_W{1'b0}}};
          if (cnt_q == LAST_CNT) begin
            // Clear instead of incrementing so the counter never wraps
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state. Data outputs are forced to zero
  // outside SEND so that idle and reset values match.
  always_comb begin
    dout       = '0;
    dout_valid = 1'b0;
    word_idx   = '0;
    last       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_SEND: begin
        dout       = sreg_q[DIG_W-1 -: NIB_W];
        dout_valid = 1'b1;
        word_idx   = 3'(cnt_q / CNT_W'(NIB_PER_WORD));
        last       = (cnt_q == LAST_CNT);
        busy       = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cout_nibble_tx.sv
// ---------------------------------------------------------------------------
// tb_cout_nibble_tx
//
// Scoreboard bench for cout_nibble_tx. Loading a digest pushes its 64
// expected nibbles (value, word index, last flag) into a queue. A negedge
// monitor compares every valid output with the head of the queue and pops
// the head on each handshake. The monitor also checks that done rises exactly
// one cycle after the final nibble is accepted, and that outputs are all zero
// while reset is held.
// ---------------------------------------------------------------------------
module tb_cout_nibble_tx;

  localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic         clk;
  logic         rst;
  logic         load;
  logic [255:0] digest;
  logic [3:0]   dout;
  logic         dout_valid;
  logic         dout_ready;
  logic [2:0]   word_idx;
  logic         last;
  logic         busy;
  logic         done;

  cout_nibble_tx #(.NIB_W(4), .DIG_W(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .digest     (digest),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .word_idx   (word_idx),
    .last       (last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] nib;
    logic [2:0] widx;
    logic       lst;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_done = 1'b0;
  logic rand_ready = 1'b0;

  // Reference model: digest split into 64 nibbles, MSB first, 8 per word
  task automatic push_expected(input logic [255:0] d);
    for (int i = 0; i < 64; i++) begin
      exp_t e;
      e.nib  = d[255 - 4*i -: 4];
      e.widx = 3'(i / 8);
      e.lst  = (i == 63);
      exp_q.push_back(e);
    end
  endtask

  // Sink ready: always 1 or a 50% coin flip, changed just after each edge
  initial begin
    dout_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ({dout, dout_valid, word_idx, last, busy, done} != 10'd0) begin
        errors++;
        $display("FAIL reset_outputs: got dout=%h valid=%b widx=%0d last=%b busy=%b done=%b, want all 0",
                 dout, dout_valid, word_idx, last, busy, done);
      end
      exp_q.delete();
      exp_done = 1'b0;
    end else begin
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL done_pulse: got done=%b want %b", done, exp_done);
      end
      exp_done = 1'b0;
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid: got dout_valid=1 dout=%h want no pending nibble", dout);
        end else begin
          exp_t e;
          e = exp_q[0];
          checks++;
          if (dout !== e.nib || word_idx !== e.widx || last !== e.lst) begin
            errors++;
            $display("FAIL nibble[%0d]: got dout=%h widx=%0d last=%b want dout=%h widx=%0d last=%b",
                     64 - exp_q.size(), dout, word_idx, last, e.nib, e.widx, e.lst);
          end
          if (dout_ready) begin
            $display("xfer nibble %0d dout=%h widx=%0d last=%b", 64 - exp_q.size(), dout, word_idx, last);
            void'(exp_q.pop_front());
            if (e.lst) exp_done = 1'b1;
          end
        end
      end
    end
  end

  // Called at posedge+1 with the DUT idle
  task automatic start(input logic [255:0] d);
    load   = 1'b1;
    digest = d;
    push_expected(d);
    @(posedge clk);
    #1;
    load   = 1'b0;
    digest = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  // Runs until the done pulse, optionally firing ignored loads while busy
  // (including in the DONE cycle). Returns at posedge+1 of the following
  // IDLE cycle, the earliest point where a new load is accepted.
  task automatic wait_done(input bit junk);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        load = junk;
        if (junk) digest = ~ABC;
      end else if (junk && busy && ($urandom_range(0, 3) == 0)) begin
        load   = 1'b1;
        digest = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end else begin
        load = 1'b0;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 2000 cycles, want done pulse");
    end
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  initial begin
    bit ok;
    rst    = 1'b0;
    load   = 1'b0;
    digest = '0;

    // 1: reset held with activity on load/ready
    rand_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      load   = ~load;
      digest = ABC;
    end
    load = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 2: "abc" digest with the sink always ready
    rand_ready = 1'b0;
    start(ABC);
    wait_done(1'b0);

    // 3: same digest under random backpressure
    rand_ready = 1'b1;
    start(ABC);
    wait_done(1'b0);

    // 4: ignored loads during SEND and DONE, then immediate reload
    start(ABC);
    wait_done(1'b1);
    start({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    wait_done(1'b0);

    // 5: reset after 20 nibbles accepted, then a full fresh transmission
    rand_ready = 1'b0;
    start(ABC);
    ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 44) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL abort_timeout: got %0d pending nibbles, want 44", exp_q.size());
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rand_ready = 1'b1;
    start(ABC);
    wait_done(1'b0);

    // 6: all-ones then all-zeros back-to-back
    start({256{1'b1}});
    wait_done(1'b0);
    start('0);
    wait_done(1'b0);

    // A few random digests under backpressure
    for (int k = 0; k < 3; k++) begin
      start({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      wait_done(1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d nibbles never sent, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
